// File: rtl/sd_cmd_sequencer.sv
// sd_cmd_sequencer: SD command issue/retry/timeout engine plus a block-by-block data transfer sequencer.
// Define SD_CMD_BUSY_WAIT_EN to add i_dat0_busy and an R1b busy wait after type-3 responses.
module sd_cmd_sequencer #(
  parameter int MAX_RETRY  = 2,
  parameter int TIMEOUT_W  = 16,
  parameter int BLK_SIZE_W = 12,
  parameter int BLK_CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_crc_enable_flag,
  input  logic [TIMEOUT_W-1:0]  i_timeout,
  input  logic                  i_cmd_en,
  input  logic [5:0]            i_cmd,
  input  logic [31:0]           i_cmd_arg,
  input  logic [1:0]            i_rsp_type,
  output logic                  o_cmd_finished_en,
  output logic                  o_error_flag,
  output logic [7:0]            o_error,
  output logic [1:0]            o_retry_count,
  output logic [127:0]          o_rsp,
  output logic                  o_phy_cmd_en,
  output logic [39:0]           o_phy_cmd,
  output logic [7:0]            o_phy_rsp_len,
  input  logic                  i_phy_rsp_finished_en,
  input  logic [135:0]          i_phy_rsp,
  input  logic                  i_phy_crc_bad,
`ifdef SD_CMD_BUSY_WAIT_EN
  input  logic                  i_dat0_busy,
`endif
  input  logic                  i_data_txrx,
  input  logic                  i_data_write_flag,
  input  logic [BLK_SIZE_W-1:0] i_block_size,
  input  logic [BLK_CNT_W-1:0]  i_block_count,
  output logic                  o_data_txrx_activate,
  input  logic                  i_data_txrx_finished,
  input  logic                  i_data_crc_read_err,
  output logic [BLK_SIZE_W-1:0] o_data_byte_count,
  output logic                  o_data_write_flag,
  output logic                  o_data_txrx_finished,
  output logic                  o_data_error_flag,
  output logic [BLK_CNT_W-1:0]  o_blocks_done
);

  localparam logic [7:0] ERR_NONE    = 8'h00;
  localparam logic [7:0] ERR_CRC     = 8'h01;
  localparam logic [7:0] ERR_TIMEOUT = 8'h02;
  localparam logic [1:0] RETRY_LIMIT = 2'(MAX_RETRY);

  typedef enum logic [2:0] {
    C_IDLE,
    C_ISSUE,
    C_WAIT_RSP,
    C_BUSY,
    C_DONE
  } cmd_state_t;

  typedef enum logic [2:0] {
    D_IDLE,
    D_ACT,
    D_WAIT_BLK,
    D_GAP,
    D_DONE
  } data_state_t;

  cmd_state_t             cmd_state, cmd_next;
  data_state_t            data_state, data_next;

  logic [1:0]             rsp_type_q;
  logic [TIMEOUT_W-1:0]   tmo_cnt;
  logic [TIMEOUT_W-1:0]   tmo_next;
  logic                   timeout_hit;
  logic                   rsp_accept;
  logic                   crc_fail;
  logic                   retry_ok;

  logic [BLK_CNT_W-1:0]   blk_count_q;
  logic                   data_start;
  logic                   blk_done;
  logic                   last_blk;

  // Upper response byte carries the start/CRC framing and is not exposed to the host.
  logic                   unused_rsp_hi;
  assign unused_rsp_hi = ^i_phy_rsp[135:128];

  assign tmo_next    = tmo_cnt + TIMEOUT_W'(1);
  assign timeout_hit = (i_timeout != '0) && (tmo_next == i_timeout);
  assign rsp_accept  = (cmd_state == C_WAIT_RSP) && i_cmd_en && i_phy_rsp_finished_en;
  assign crc_fail    = i_crc_enable_flag && i_phy_crc_bad;
  assign retry_ok    = o_retry_count < RETRY_LIMIT;

  // ---------------- command FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) cmd_state <= C_IDLE;
    else     cmd_state <= cmd_next;
  end

  always_comb begin
    cmd_next = cmd_state;
    if (!i_cmd_en) begin
      cmd_next = C_IDLE;
    end else begin
      case (cmd_state)
        C_IDLE:  cmd_next = C_ISSUE;
        C_ISSUE: cmd_next = (rsp_type_q == 2'd0) ? C_DONE : C_WAIT_RSP;
        C_WAIT_RSP: begin
          // A response arriving on the timeout cycle takes priority.
          if (i_phy_rsp_finished_en) begin
            if (crc_fail && retry_ok)
              cmd_next = C_ISSUE;
            else if (crc_fail)
              cmd_next = C_DONE;
`ifdef SD_CMD_BUSY_WAIT_EN
            else if (rsp_type_q == 2'd3)
              cmd_next = C_BUSY;
`endif
            else
              cmd_next = C_DONE;
          end else if (timeout_hit) begin
            cmd_next = C_DONE;
          end
        end
`ifdef SD_CMD_BUSY_WAIT_EN
        C_BUSY: begin
          if (!i_dat0_busy)     cmd_next = C_DONE;
          else if (timeout_hit) cmd_next = C_DONE;
        end
`endif
        C_DONE:  cmd_next = C_DONE;
        default: cmd_next = C_IDLE;
      endcase
    end
  end

  always_comb begin
    o_phy_cmd_en      = 1'b0;
    o_cmd_finished_en = 1'b0;
    o_error_flag      = 1'b0;
    case (cmd_state)
      C_ISSUE: o_phy_cmd_en = i_cmd_en;
      C_DONE: begin
        o_cmd_finished_en = 1'b1;
        o_error_flag      = (o_error != ERR_NONE);
      end
      default: ;
    endcase
    case (rsp_type_q)
      2'd0:    o_phy_rsp_len = 8'd0;
      2'd2:    o_phy_rsp_len = 8'd136;
      default: o_phy_rsp_len = 8'd40;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_phy_cmd     <= '0;
      rsp_type_q    <= '0;
      o_error       <= ERR_NONE;
      o_retry_count <= '0;
      o_rsp         <= '0;
      tmo_cnt       <= '0;
    end else begin
      case (cmd_state)
        C_IDLE: begin
          o_error       <= ERR_NONE;
          o_retry_count <= '0;
          if (i_cmd_en) begin
            o_phy_cmd  <= {2'b01, i_cmd, i_cmd_arg};
            rsp_type_q <= i_rsp_type;
          end
        end
        C_ISSUE: tmo_cnt <= '0;
        C_WAIT_RSP: begin
          tmo_cnt <= tmo_next;
          if (rsp_accept) begin
            o_rsp <= i_phy_rsp[127:0];
            if (crc_fail && retry_ok)
              o_retry_count <= o_retry_count + 2'd1;
            else if (crc_fail)
              o_error <= ERR_CRC;
          end else if (i_cmd_en && timeout_hit) begin
            o_error <= ERR_TIMEOUT;
          end
        end
`ifdef SD_CMD_BUSY_WAIT_EN
        C_BUSY: begin
          tmo_cnt <= tmo_next;
          if (i_cmd_en && i_dat0_busy && timeout_hit)
            o_error <= ERR_TIMEOUT;
        end
`endif
        default: ;
      endcase
    end
  end

  // ---------------- data FSM ----------------
  assign data_start = (data_state == D_IDLE) && i_data_txrx;
  assign blk_done   = (data_state == D_WAIT_BLK) && i_data_txrx && i_data_txrx_finished;
  assign last_blk   = (o_blocks_done + BLK_CNT_W'(1)) == blk_count_q;

  assign o_data_byte_count = i_block_size;
  assign o_data_write_flag = i_data_write_flag;

  always_ff @(posedge clk) begin
    if (rst) data_state <= D_IDLE;
    else     data_state <= data_next;
  end

  always_comb begin
    data_next = data_state;
    if (!i_data_txrx) begin
      data_next = D_IDLE;
    end else begin
      case (data_state)
        D_IDLE:     data_next = D_ACT;
        D_ACT:      data_next = D_WAIT_BLK;
        D_WAIT_BLK: begin
          if (i_data_txrx_finished)
            data_next = (i_data_crc_read_err || last_blk) ? D_DONE : D_GAP;
        end
        D_GAP:      data_next = D_ACT;
        D_DONE:     data_next = D_DONE;
        default:    data_next = D_IDLE;
      endcase
    end
  end

  always_comb begin
    o_data_txrx_activate = 1'b0;
    o_data_txrx_finished = 1'b0;
    case (data_state)
      D_ACT, D_WAIT_BLK: o_data_txrx_activate = i_data_txrx;
      D_DONE:            o_data_txrx_finished = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_count_q       <= '0;
      o_blocks_done     <= '0;
      o_data_error_flag <= 1'b0;
    end else if (data_start) begin
      blk_count_q       <= (i_block_count == '0) ? BLK_CNT_W'(1) : i_block_count;
      o_blocks_done     <= '0;
      o_data_error_flag <= 1'b0;
    end else if (blk_done) begin
      o_blocks_done <= o_blocks_done + BLK_CNT_W'(1);
      if (i_data_crc_read_err)
        o_data_error_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// tb_sd_cmd_sequencer: directed vectors with hand-computed expectations for sd_cmd_sequencer.
module tb_sd_cmd_sequencer;

  localparam int TIMEOUT_W  = 16;
  localparam int BLK_SIZE_W = 12;
  localparam int BLK_CNT_W  = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  i_crc_enable_flag;
  logic [TIMEOUT_W-1:0]  i_timeout;
  logic                  i_cmd_en;
  logic [5:0]            i_cmd;
  logic [31:0]           i_cmd_arg;
  logic [1:0]            i_rsp_type;
  logic                  o_cmd_finished_en;
  logic                  o_error_flag;
  logic [7:0]            o_error;
  logic [1:0]            o_retry_count;
  logic [127:0]          o_rsp;
  logic                  o_phy_cmd_en;
  logic [39:0]           o_phy_cmd;
  logic [7:0]            o_phy_rsp_len;
  logic                  i_phy_rsp_finished_en;
  logic [135:0]          i_phy_rsp;
  logic                  i_phy_crc_bad;
`ifdef SD_CMD_BUSY_WAIT_EN
  logic                  i_dat0_busy = 1'b0;
`endif
  logic                  i_data_txrx;
  logic                  i_data_write_flag;
  logic [BLK_SIZE_W-1:0] i_block_size;
  logic [BLK_CNT_W-1:0]  i_block_count;
  logic                  o_data_txrx_activate;
  logic                  i_data_txrx_finished;
  logic                  i_data_crc_read_err;
  logic [BLK_SIZE_W-1:0] o_data_byte_count;
  logic                  o_data_write_flag;
  logic                  o_data_txrx_finished;
  logic                  o_data_error_flag;
  logic [BLK_CNT_W-1:0]  o_blocks_done;

  int tests_run    = 0;
  int tests_failed = 0;

  int   issue_cnt = 0;
  int   act_rise  = 0;
  int   low_run   = 0;
  int   last_gap  = -1;
  logic act_prev  = 1'b0;

  always #5 clk = ~clk;

  sd_cmd_sequencer #(
    .MAX_RETRY(2), .TIMEOUT_W(TIMEOUT_W), .BLK_SIZE_W(BLK_SIZE_W), .BLK_CNT_W(BLK_CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .i_crc_enable_flag(i_crc_enable_flag), .i_timeout(i_timeout),
    .i_cmd_en(i_cmd_en), .i_cmd(i_cmd), .i_cmd_arg(i_cmd_arg), .i_rsp_type(i_rsp_type),
    .o_cmd_finished_en(o_cmd_finished_en), .o_error_flag(o_error_flag), .o_error(o_error),
    .o_retry_count(o_retry_count), .o_rsp(o_rsp),
    .o_phy_cmd_en(o_phy_cmd_en), .o_phy_cmd(o_phy_cmd), .o_phy_rsp_len(o_phy_rsp_len),
    .i_phy_rsp_finished_en(i_phy_rsp_finished_en), .i_phy_rsp(i_phy_rsp), .i_phy_crc_bad(i_phy_crc_bad),
`ifdef SD_CMD_BUSY_WAIT_EN
    .i_dat0_busy(i_dat0_busy),
`endif
    .i_data_txrx(i_data_txrx), .i_data_write_flag(i_data_write_flag),
    .i_block_size(i_block_size), .i_block_count(i_block_count),
    .o_data_txrx_activate(o_data_txrx_activate), .i_data_txrx_finished(i_data_txrx_finished),
    .i_data_crc_read_err(i_data_crc_read_err), .o_data_byte_count(o_data_byte_count),
    .o_data_write_flag(o_data_write_flag), .o_data_txrx_finished(o_data_txrx_finished),
    .o_data_error_flag(o_data_error_flag), .o_blocks_done(o_blocks_done)
  );

  // Counts command issues, activate pulses and the idle gap preceding each activate pulse.
  always @(negedge clk) begin
    if (o_phy_cmd_en) issue_cnt++;
    if (o_data_txrx_activate && !act_prev) begin
      act_rise++;
      last_gap = low_run;
    end
    if (o_data_txrx_activate) low_run = 0;
    else                      low_run++;
    act_prev = o_data_txrx_activate;
  end

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [5:0] cmd, input logic [31:0] arg, input logic [1:0] rsp_type);
    i_cmd      = cmd;
    i_cmd_arg  = arg;
    i_rsp_type = rsp_type;
    i_cmd_en   = 1'b1;
  endtask

  task automatic respond(input logic crc_bad, input logic [135:0] data);
    repeat (3) tick();
    i_phy_rsp             = data;
    i_phy_crc_bad         = crc_bad;
    i_phy_rsp_finished_en = 1'b1;
    tick();
    i_phy_rsp_finished_en = 1'b0;
    i_phy_crc_bad         = 1'b0;
  endtask

  task automatic waitActivate(input string tag);
    int n = 0;
    while (!o_data_txrx_activate && n < 50) begin
      tick();
      n++;
    end
    if (!o_data_txrx_activate) checkOutput(tag, 128'd0, 128'd1);
  endtask

  task automatic runBlock(input logic crc_err);
    waitActivate("blk_activate_wait");
    repeat (2) tick();
    i_data_crc_read_err  = crc_err;
    i_data_txrx_finished = 1'b1;
    tick();
    i_data_txrx_finished = 1'b0;
    i_data_crc_read_err  = 1'b0;
  endtask

  task automatic dropCmd();
    i_cmd_en = 1'b0;
    tick();
  endtask

  initial begin
    int base_i;
    int base_a;
    rst = 1'b1;
    i_crc_enable_flag = 1'b0; i_timeout = '0; i_cmd_en = 1'b0; i_cmd = '0; i_cmd_arg = '0;
    i_rsp_type = '0; i_phy_rsp_finished_en = 1'b0; i_phy_rsp = '0; i_phy_crc_bad = 1'b0;
    i_data_txrx = 1'b0; i_data_write_flag = 1'b0; i_block_size = '0; i_block_count = '0;
    i_data_txrx_finished = 1'b0; i_data_crc_read_err = 1'b0;
    repeat (3) tick();

    checkOutput("rst_cmd_finished", 128'(o_cmd_finished_en), 128'd0);
    checkOutput("rst_error", 128'(o_error), 128'd0);
    checkOutput("rst_retry", 128'(o_retry_count), 128'd0);
    checkOutput("rst_rsp", o_rsp, 128'd0);
    checkOutput("rst_phy_cmd", 128'(o_phy_cmd), 128'd0);
    checkOutput("rst_phy_cmd_en", 128'(o_phy_cmd_en), 128'd0);
    checkOutput("rst_rsp_len", 128'(o_phy_rsp_len), 128'd0);
    checkOutput("rst_blocks_done", 128'(o_blocks_done), 128'd0);
    checkOutput("rst_activate", 128'(o_data_txrx_activate), 128'd0);
    checkOutput("rst_data_finished", 128'(o_data_txrx_finished), 128'd0);
    checkOutput("rst_data_err", 128'(o_data_error_flag), 128'd0);
    rst = 1'b0;
    tick();

    // CMD8 with a clean short response
    base_i = issue_cnt;
    applyStimulus(6'd8, 32'h0000_01AA, 2'd1);
    repeat (5) tick();
    i_phy_rsp = 136'h5A_0000_1111_2222_3333_4444_5555_6666_7777;
    i_phy_rsp_finished_en = 1'b1;
    tick();
    i_phy_rsp_finished_en = 1'b0;
    checkOutput("cmd8_finished", 128'(o_cmd_finished_en), 128'd1);
    checkOutput("cmd8_error", 128'(o_error), 128'd0);
    checkOutput("cmd8_error_flag", 128'(o_error_flag), 128'd0);
    checkOutput("cmd8_phy_cmd", 128'(o_phy_cmd), 128'h48_0000_01AA);
    checkOutput("cmd8_rsp_len", 128'(o_phy_rsp_len), 128'd40);
    checkOutput("cmd8_rsp", o_rsp, 128'h0000_1111_2222_3333_4444_5555_6666_7777);
    checkOutput("cmd8_issues", 128'(issue_cnt - base_i), 128'd1);
    dropCmd();
    checkOutput("cmd8_ack_cleared", 128'(o_cmd_finished_en), 128'd0);

    // No-response command completes right after its issue
    applyStimulus(6'd0, 32'h0, 2'd0);
    tick();
    checkOutput("cmd0_rsp_len", 128'(o_phy_rsp_len), 128'd0);
    tick();
    checkOutput("cmd0_finished", 128'(o_cmd_finished_en), 128'd1);
    dropCmd();

    // CRC failures on every response exhaust the two retries
    i_crc_enable_flag = 1'b1;
    base_i = issue_cnt;
    applyStimulus(6'd17, 32'h0000_0200, 2'd1);
    respond(1'b1, 136'h00_AAAA_0000_0000_0000_0000_0000_0000_0001);
    checkOutput("retry_first", 128'(o_retry_count), 128'd1);
    respond(1'b1, 136'h00_AAAA_0000_0000_0000_0000_0000_0000_0002);
    respond(1'b1, 136'h00_AAAA_0000_0000_0000_0000_0000_0000_0003);
    checkOutput("retry_issues", 128'(issue_cnt - base_i), 128'd3);
    checkOutput("retry_count", 128'(o_retry_count), 128'd2);
    checkOutput("retry_error", 128'(o_error), 128'd1);
    checkOutput("retry_error_flag", 128'(o_error_flag), 128'd1);
    checkOutput("retry_finished", 128'(o_cmd_finished_en), 128'd1);
    checkOutput("retry_rsp", o_rsp, 128'hAAAA_0000_0000_0000_0000_0000_0000_0003);
    dropCmd();

    // One bad CRC followed by a good response
    base_i = issue_cnt;
    applyStimulus(6'd17, 32'h0000_0400, 2'd1);
    respond(1'b1, 136'h0);
    respond(1'b0, 136'h0);
    checkOutput("recover_retry", 128'(o_retry_count), 128'd1);
    checkOutput("recover_error", 128'(o_error), 128'd0);
    checkOutput("recover_issues", 128'(issue_cnt - base_i), 128'd2);
    dropCmd();

    // Bad CRC is ignored while checking is off
    i_crc_enable_flag = 1'b0;
    base_i = issue_cnt;
    applyStimulus(6'd13, 32'h0, 2'd1);
    respond(1'b1, 136'h0);
    checkOutput("nocrc_finished", 128'(o_cmd_finished_en), 128'd1);
    checkOutput("nocrc_error", 128'(o_error), 128'd0);
    checkOutput("nocrc_issues", 128'(issue_cnt - base_i), 128'd1);
    dropCmd();
    i_crc_enable_flag = 1'b1;

    // Timeout after exactly 20 response-wait cycles
    i_timeout = 16'd20;
    applyStimulus(6'd55, 32'h0, 2'd1);
    repeat (21) tick();
    checkOutput("tmo_not_yet", 128'(o_cmd_finished_en), 128'd0);
    tick();
    checkOutput("tmo_finished", 128'(o_cmd_finished_en), 128'd1);
    checkOutput("tmo_error", 128'(o_error), 128'd2);
    checkOutput("tmo_error_flag", 128'(o_error_flag), 128'd1);
    dropCmd();

    // Response on the timeout cycle wins
    applyStimulus(6'd55, 32'h0, 2'd1);
    repeat (21) tick();
    i_phy_rsp = 136'h00_BEEF_0000_0000_0000_0000_0000_0000_CAFE;
    i_phy_rsp_finished_en = 1'b1;
    tick();
    i_phy_rsp_finished_en = 1'b0;
    checkOutput("tmo_race_finished", 128'(o_cmd_finished_en), 128'd1);
    checkOutput("tmo_race_error", 128'(o_error), 128'd0);
    checkOutput("tmo_race_rsp", o_rsp, 128'hBEEF_0000_0000_0000_0000_0000_0000_CAFE);
    dropCmd();

    // Timeout disabled: waits indefinitely; then abort and a dropped in-flight issue
    i_timeout = 16'd0;
    applyStimulus(6'd2, 32'h0, 2'd2);
    repeat (100) tick();
    checkOutput("notmo_waiting", 128'(o_cmd_finished_en), 128'd0);
    checkOutput("long_rsp_len", 128'(o_phy_rsp_len), 128'd136);
    dropCmd();
    base_i = issue_cnt;
    applyStimulus(6'd3, 32'h0, 2'd3);
    tick();
    checkOutput("abort_reissue", 128'(o_phy_cmd_en), 128'd1);
    checkOutput("r1b_rsp_len", 128'(o_phy_rsp_len), 128'd40);
    i_cmd_en = 1'b0;
    #1;
    checkOutput("abort_issue_gated", 128'(o_phy_cmd_en), 128'd0);
    tick();
    checkOutput("abort_issue_count", 128'(issue_cnt - base_i), 128'd0);

    // Three 512-byte blocks with single-cycle gaps
    i_block_size = 12'd512;
    i_block_count = 16'd3;
    i_data_write_flag = 1'b1;
    base_a = act_rise;
    i_data_txrx = 1'b1;
    runBlock(1'b0);
    runBlock(1'b0);
    runBlock(1'b0);
    checkOutput("blk3_done", 128'(o_blocks_done), 128'd3);
    checkOutput("blk3_finished", 128'(o_data_txrx_finished), 128'd1);
    checkOutput("blk3_error", 128'(o_data_error_flag), 128'd0);
    checkOutput("blk3_activates", 128'(act_rise - base_a), 128'd3);
    checkOutput("blk3_gap", 128'(last_gap), 128'd1);
    checkOutput("blk3_byte_count", 128'(o_data_byte_count), 128'd512);
    checkOutput("blk3_write_flag", 128'(o_data_write_flag), 128'd1);
    checkOutput("blk3_activate_off", 128'(o_data_txrx_activate), 128'd0);
    i_data_txrx = 1'b0;
    tick();
    checkOutput("blk3_ack_cleared", 128'(o_data_txrx_finished), 128'd0);

    // CRC error on block 2 of 4 stops the transfer
    i_block_count = 16'd4;
    i_data_write_flag = 1'b0;
    base_a = act_rise;
    i_data_txrx = 1'b1;
    runBlock(1'b0);
    runBlock(1'b1);
    repeat (5) tick();
    checkOutput("blkerr_done", 128'(o_blocks_done), 128'd2);
    checkOutput("blkerr_flag", 128'(o_data_error_flag), 128'd1);
    checkOutput("blkerr_finished", 128'(o_data_txrx_finished), 128'd1);
    checkOutput("blkerr_activates", 128'(act_rise - base_a), 128'd2);
    checkOutput("blkerr_write_flag", 128'(o_data_write_flag), 128'd0);
    i_data_txrx = 1'b0;
    tick();

    // Block count 0 behaves as a single block
    i_block_count = 16'd0;
    i_data_txrx = 1'b1;
    runBlock(1'b0);
    checkOutput("blk0_finished", 128'(o_data_txrx_finished), 128'd1);
    checkOutput("blk0_done", 128'(o_blocks_done), 128'd1);
    i_data_txrx = 1'b0;
    tick();

    // Abort mid-block, then a fresh single-block transfer
    i_block_count = 16'd2;
    i_data_txrx = 1'b1;
    waitActivate("abort_activate_wait");
    tick();
    i_data_txrx = 1'b0;
    #1;
    checkOutput("dabort_activate", 128'(o_data_txrx_activate), 128'd0);
    tick();
    checkOutput("dabort_finished", 128'(o_data_txrx_finished), 128'd0);
    i_block_count = 16'd1;
    i_data_txrx = 1'b1;
    tick();
    checkOutput("drestart_activate", 128'(o_data_txrx_activate), 128'd1);
    runBlock(1'b0);
    checkOutput("drestart_finished", 128'(o_data_txrx_finished), 128'd1);
    checkOutput("drestart_done", 128'(o_blocks_done), 128'd1);
    i_data_txrx = 1'b0;
    tick();

    // Reset in the middle of a command and a transfer
    applyStimulus(6'd18, 32'h0, 2'd1);
    i_block_count = 16'd3;
    i_data_txrx = 1'b1;
    runBlock(1'b0);
    checkOutput("midrst_pre_done", 128'(o_blocks_done), 128'd1);
    rst = 1'b1;
    tick();
    checkOutput("midrst_rsp", o_rsp, 128'd0);
    checkOutput("midrst_blocks", 128'(o_blocks_done), 128'd0);
    checkOutput("midrst_activate", 128'(o_data_txrx_activate), 128'd0);
    checkOutput("midrst_phy_cmd", 128'(o_phy_cmd), 128'd0);
    checkOutput("midrst_cmd_en", 128'(o_phy_cmd_en), 128'd0);
    checkOutput("midrst_finished", 128'(o_cmd_finished_en), 128'd0);
    rst = 1'b0;
    i_cmd_en = 1'b0;
    i_data_txrx = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
